// File: rtl/dig_ct.sv
// Registered decode of five status inputs into three active-low flags.
// Every output is a plain flop with one cycle of latency.
module dig_ct #(
  parameter logic [2:0] OUT_RST = 3'b111
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in1,
  input  logic in2,
  input  logic in3,
  input  logic in4,
  input  logic in5,
  output logic out1,
  output logic out2,
  output logic out3
);

  logic out1_d;
  logic out2_d;
  logic out3_d;

  // The flags are active-low: a term that asserts drives its flag to 0.
  always_comb begin
    out1_d = ~(in3 & ~in2 & ~in1);
    out2_d = ~(in2 & in3);
    out3_d = ~(in4 & ~in5);
  end

  // NOTE: non-blocking assignments keep all three flops sampling the same
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {out3, out2, out1} <= OUT_RST;
    end else begin
      out1 <= out1_d;
      out2 <= out2_d;
      out3 <= out3_d;
    end
  end

endmodule

// File: tb/tb_dig_ct.sv
// Self-checking bench for dig_ct: stimulus pushes expected flags into a
// queue, an independent monitor pops and compares after each rising edge.
module tb_dig_ct;

  logic clk;
  logic rst_n;
  logic in1, in2, in3, in4, in5;
  logic out1, out2, out3;

  int n_cmp;
  int n_fail;

  logic [2:0] exp_q[$];

  dig_ct #(.OUT_RST(3'b111)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in1  (in1),
    .in2  (in2),
    .in3  (in3),
    .in4  (in4),
    .in5  (in5),
    .out1 (out1),
    .out2 (out2),
    .out3 (out3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout {in5,in4,in3,in2,in1}; flag layout {out3,out2,out1}.
  function automatic logic [2:0] model(input logic [4:0] v);
    logic a1, a2, a3;
    a1 = v[2] && !v[1] && !v[0];
    a2 = v[1] && v[2];
    a3 = v[3] && !v[4];
    return {!a3, !a2, !a1};
  endfunction

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got {out3,out2,out1}=%b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic set_inputs(input logic [4:0] v);
    {in5, in4, in3, in2, in1} = v;
  endtask

  task automatic drive(input logic [4:0] v, input logic [2:0] req);
    @(negedge clk);
    set_inputs(v);
    exp_q.push_back(req);
  endtask

  // Monitor: every edge out of reset with a pending expectation is compared.
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      check("scoreboard", {out3, out2, out1}, exp_q.pop_front());
    end
  end

  typedef struct {
    logic [4:0] v;
    logic [2:0] req;
  } vec_t;

  vec_t vecs[$] = '{
    '{5'b00000, 3'b111},   // idle
    '{5'b00100, 3'b110},   // in3 alone
    '{5'b00101, 3'b111},   // in3 qualified by in1
    '{5'b00110, 3'b101},   // in2 & in3
    '{5'b01000, 3'b011},   // in4 with in5 clear
    '{5'b11000, 3'b111},   // in4 qualified by in5
    '{5'b11111, 3'b101},   // all inputs high
    '{5'b01110, 3'b001}    // two flags asserted together
  };

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    set_inputs(5'b01110);

    // Reset holds the flags deasserted even while clocking active inputs.
    repeat (3) begin
      @(negedge clk);
      check("reset_hold", {out3, out2, out1}, 3'b111);
    end

    @(negedge clk);
    set_inputs(5'b00000);
    rst_n = 1'b1;

    foreach (vecs[i]) drive(vecs[i].v, vecs[i].req);

    // Mid-cycle input change must not reach the outputs before the next edge.
    drive(5'b00100, 3'b110);
    @(posedge clk);
    #3;
    set_inputs(5'b01000);
    #1;
    check("latency_hold", {out3, out2, out1}, 3'b110);
    drive(5'b01000, 3'b011);

    // Sweep all 32 codes against the reference model.
    for (int c = 0; c < 32; c++) drive(5'(c), model(5'(c)));

    // Asynchronous reset mid-run with flags asserted.
    drive(5'b01110, 3'b001);
    @(posedge clk);
    #2;
    check("pre_async_reset", {out3, out2, out1}, 3'b001);
    rst_n = 1'b0;
    #1;
    check("async_reset", {out3, out2, out1}, 3'b111);
    @(posedge clk);
    #1;
    check("async_reset_hold", {out3, out2, out1}, 3'b111);

    // Release is sampled at the next rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_no_edge", {out3, out2, out1}, 3'b111);
    drive(5'b00110, 3'b101);

    // Bounded drain of the scoreboard.
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
